// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, FSM states and the {hi,lo} result payload.
package e_mdu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/e_mdu.sv
// Execute-stage MDU: multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO,
// MTHI/MTLO writes, and stall request for the hazard unit.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [2:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Stall_req,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            pend_q, pend_d;
  logic             pend_we_q, pend_we_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;

  mdu_op_e              op_e;
  logic                 op_multi, op_div;
  logic signed [2*XLEN-1:0] smul_a, smul_b, smul_p;
  logic [2*XLEN-1:0]    umul_p;
  logic                 a_neg, b_neg, b_zero;
  logic [XLEN-1:0]      den_u, a_mag, b_mag, uq, ur, mq, mr;
  hilo_t                start_res;

  // Result datapath; signed divide works on magnitudes so MIN/-1 wraps cleanly.
  always_comb begin
    op_e     = mdu_op_e'(Op);
    op_multi = (op_e == MDU_MULT) || (op_e == MDU_MULTU) ||
               (op_e == MDU_DIV)  || (op_e == MDU_DIVU);
    op_div   = (op_e == MDU_DIV)  || (op_e == MDU_DIVU);
    smul_a   = {{XLEN{A[XLEN-1]}}, A};
    smul_b   = {{XLEN{B[XLEN-1]}}, B};
    smul_p   = smul_a * smul_b;
    umul_p   = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};
    b_zero   = (B == '0);
    a_neg    = A[XLEN-1];
    b_neg    = B[XLEN-1];
    den_u    = b_zero ? XLEN'(1) : B;
    uq       = A / den_u;
    ur       = A % den_u;
    a_mag    = a_neg ? -A : A;
    b_mag    = b_zero ? XLEN'(1) : (b_neg ? -B : B);
    mq       = a_mag / b_mag;
    mr       = a_mag % b_mag;
    start_res = '0;
    unique case (op_e)
      MDU_MULT:  start_res = hilo_t'(smul_p);
      MDU_MULTU: start_res = hilo_t'(umul_p);
      MDU_DIV: begin
        start_res.lo = (a_neg ^ b_neg) ? -mq : mq;
        start_res.hi = a_neg ? -mr : mr;
      end
      MDU_DIVU: begin
        start_res.lo = uq;
        start_res.hi = ur;
      end
      default: start_res = '0;
    endcase
  end

  // Next-state: issue in IDLE, count down in RUN, commit on the last edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start && op_multi) begin
          state_d   = ST_RUN;
          busy_d    = 1'b1;
          pend_d    = start_res;
          pend_we_d = !(op_div && b_zero);
          cnt_d     = op_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end else if (Start && (op_e == MDU_MTHI)) begin
          hi_d = A;
        end else if (Start && (op_e == MDU_MTLO)) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (pend_we_q) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign Busy      = busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign Stall_req = busy_q | (Start & op_multi);

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO queued at issue, checked when Busy drops.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Stall_req;
  logic [31:0] HI, LO;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] committed;
  logic [63:0] r, e;
  int          cnt;

  always #5 Clk = ~Clk;

  e_mdu dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Stall_req(Stall_req), .HI(HI), .LO(LO)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fails++;
      $display("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    int     sa, sb;
    longint sp;
    sa = int'(a);
    sb = int'(b);
    sp = longint'(sa) * longint'(sb);
    case (op)
      3'd1: return 64'(sp);
      3'd2: return {32'h0, a} * {32'h0, b};
      3'd3: begin
        if (b == 32'h0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: begin
        if (b == 32'h0) return cur;
        return {a % b, a / b};
      end
      3'd5: return {a, cur[31:0]};
      3'd6: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  // One op: drive on negedge, scramble operands while busy, check on completion.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int n);
    int          c;
    logic [63:0] ev;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    #1 chk("stall_start", 64'(Stall_req), 64'(n > 0));
    exp_q.push_back({eh, el});
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0; A = $urandom; B = $urandom;
    c = 0;
    while (Busy === 1'b1 && c < 64) begin
      chk("stall_busy", 64'(Stall_req), 64'd1);
      chk("hilo_hidden", {HI, LO}, committed);
      c++;
      @(negedge Clk);
      A = $urandom; B = $urandom;
    end
    chk("busy_len", 64'(c), 64'(n));
    ev = exp_q.pop_front();
    chk("hilo", {HI, LO}, ev);
    committed = ev;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    committed = '0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_stall", 64'(Stall_req), 64'd0);
    Rst = 1'b1;

    // MTHI then MTLO back to back
    @(negedge Clk);
    Start = 1'b1; Op = 3'd5; A = 32'hDEAD_BEEF;
    #1 chk("mthi_stall", 64'(Stall_req), 64'd0);
    @(negedge Clk);
    chk("mthi_hi", 64'(HI), 64'hDEAD_BEEF);
    chk("mthi_lo", 64'(LO), 64'd0);
    chk("mthi_busy", 64'(Busy), 64'd0);
    Op = 3'd6; A = 32'h1;
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
    chk("mtlo_hilo", {HI, LO}, {32'hDEAD_BEEF, 32'h1});
    chk("mtlo_busy", 64'(Busy), 64'd0);
    committed = {HI == HI ? 32'hDEAD_BEEF : 32'h0, 32'h1};

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
    issue(3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
    issue(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);

    // DIVU by zero leaves preset HI/LO intact
    issue(3'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, committed[31:0], 0);
    issue(3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h1234_5678, 0);
    issue(3'd4, 32'd7, 32'd0, 32'h1234_5678, 32'h1234_5678, 10);

    // Op NONE and Op 7 with Start do nothing
    issue(3'd0, 32'hAAAA_AAAA, 32'd1, committed[63:32], committed[31:0], 0);
    issue(3'd7, 32'hBBBB_BBBB, 32'd1, committed[63:32], committed[31:0], 0);

    // Start MULT on the 3rd busy cycle of a DIV: must be ignored
    @(negedge Clk);
    Start = 1'b1; Op = 3'd3; A = 32'd20; B = 32'd3;
    #1 chk("coll_stall_start", 64'(Stall_req), 64'd1);
    exp_q.push_back({32'd2, 32'd6});
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 64) begin
      chk("coll_stall_busy", 64'(Stall_req), 64'd1);
      chk("coll_hidden", {HI, LO}, committed);
      cnt++;
      if (cnt == 3) begin
        Start = 1'b1; Op = 3'd1; A = 32'd5; B = 32'd5;
      end else begin
        Start = 1'b0; Op = 3'd0;
      end
      @(negedge Clk);
    end
    chk("coll_busy_len", 64'(cnt), 64'd10);
    e = exp_q.pop_front();
    chk("coll_hilo", {HI, LO}, e);
    committed = e;
    @(negedge Clk);
    chk("coll_no_restart", 64'(Busy), 64'd0);
    chk("coll_hilo_hold", {HI, LO}, committed);

    // Randomised ops against the model
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          n;
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (op == 3'd3 && a == 32'h8000_0000) a = 32'h7FFF_0000;
      n  = (op <= 3'd2) ? 5 : ((op <= 3'd4) ? 10 : 0);
      r  = model(op, a, b, committed);
      issue(op, a, b, r[63:32], r[31:0], n);
    end

    // Async reset in the middle of a MULT
    @(negedge Clk);
    Start = 1'b1; Op = 3'd1; A = 32'd9; B = 32'd9;
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_hilo", {HI, LO}, 64'd0);
    chk("midrst_stall", 64'(Stall_req), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    repeat (7) @(negedge Clk);
    chk("postrst_busy", 64'(Busy), 64'd0);
    chk("postrst_hilo", {HI, LO}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
